// File: rtl/audio_sd_dac.sv
// Mixes OPL2, Tandy PSG and PC speaker into a 16-bit offset-binary sample driving a 1-bit
// sigma-delta DAC. Define AUDIO_SD_2ND_ORDER_EN for the second-order modulator.
module audio_sd_dac (
   input  logic        clk_vga,
   input  logic        reset_n,
   input  logic        sample_en,
   input  logic [15:0] opl2_snd,
   input  logic [9:0]  tandy_snd,
   input  logic        speaker,
   input  logic        mute,
   input  logic        clip_clr,
   output logic        aud_l,
   output logic        aud_r,
   output logic        clip,
   output logic [15:0] sample_q
);

   logic [17:0] mix;
   logic        over, under, sat;
   logic [15:0] clamped, conv;
   logic        armed_q;
   logic        latch;
   logic [15:0] sample_d;
   logic        clip_q, clip_d;
   logic        out_q;

   // Two's-complement sum of the three sources, all terms pre-aligned to 18 bits.
   assign mix = {opl2_snd[15], opl2_snd, 1'b0}
              + {{2{tandy_snd[9]}}, tandy_snd, 6'b0}
              + {4'b0, speaker, 13'b0};

   always_comb begin
      over    = ~mix[17] & (mix[16] | mix[15]);
      under   = mix[17] & ~(mix[16] & mix[15]);
      sat     = over | under;
      clamped = mix[15:0];
      if (over) begin
         clamped = 16'h7FFF;
      end else if (under) begin
         clamped = 16'h8000;
      end
      conv = {~clamped[15], clamped[14:0]};
   end

   // A strobe on the first edge after reset release is dropped.
   assign latch = sample_en & armed_q;

   always_comb begin
      sample_d = sample_q;
      clip_d   = clip_q;
      if (latch) begin
         sample_d = mute ? 16'h8000 : conv;
      end
      if (clip_clr) begin
         clip_d = 1'b0;
      end
      if (latch && !mute && sat) begin
         clip_d = 1'b1;
      end
   end

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         armed_q  <= 1'b0;
         sample_q <= 16'h8000;
         clip_q   <= 1'b0;
      end else begin
         armed_q  <= 1'b1;
         sample_q <= sample_d;
         clip_q   <= clip_d;
      end
   end

`ifdef AUDIO_SD_2ND_ORDER_EN
   logic signed [20:0] i1_q, i2_q, i1_d, i2_d;
   logic signed [22:0] fb, i1_sum, i2_sum;

   function automatic logic signed [20:0] sat21(input logic signed [22:0] v);
      if (v > 23'sd1048575) begin
         return 21'sh0FFFFF;
      end else if (v < -23'sd1048576) begin
         return 21'sh100000;
      end
      return v[20:0];
   endfunction

   always_comb begin
      fb     = out_q ? 23'sd65535 : 23'sd0;
      i1_sum = 23'(i1_q) + $signed({7'b0, sample_q}) - fb;
      i2_sum = 23'(i2_q) + 23'(i1_q) - fb;
      i1_d   = sat21(i1_sum);
      i2_d   = sat21(i2_sum);
   end

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         i1_q  <= '0;
         i2_q  <= '0;
         out_q <= 1'b0;
      end else begin
         i1_q  <= i1_d;
         i2_q  <= i2_d;
         out_q <= ~i2_d[20];
      end
   end
`else
   logic [16:0] acc_q, acc_d;

   // Carry out of the 16-bit phase accumulator is the output bit.
   assign acc_d = {1'b0, acc_q[15:0]} + {1'b0, sample_q};

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         out_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         out_q <= acc_q[16];
      end
   end
`endif

   assign aud_l = out_q;
   assign aud_r = out_q;
   assign clip  = clip_q;

endmodule
